instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
Fetch stage that sits directly upstream of the instruction memory. It drives the memory address, write-data and write-enable lines. It has two jobs:
- Boot: loads a program into the memory through a valid/ready handshake.
- Run: keeps a word-addressed PC, reads the combinational memory output, and registers instruction/PC/valid into the IF/ID pipeline register. It supports stall, branch redirect with flush, and halt.

Parameters:
DATA_WIDTH, 16, instruction and memory word width
ADDR_WIDTH, 16, PC and memory address width
MEM_SIZE, 1024, number of memory words; loader address limit
RESET_PC, 0, PC value on reset and after load completes
HALT_INSTR, 16'hFFFF, encoding that stops fetching

Ports:
clk  in  1  clock, all state changes on posedge
rst  in  1  reset, asynchronous, active-high
load_mode  in  1  sampled in S_WAIT: 1 = boot-load first, 0 = run directly
load_valid  in  1  loader word present
load_data  in  DATA_WIDTH  loader word
load_last  in  1  marks final loader word
load_ready  out  1  loader word accepted this cycle
load_overflow  out  1  sticky: load truncated at MEM_SIZE
imem_addr  out  ADDR_WIDTH  memory address (combinational)
imem_data  out  DATA_WIDTH  memory write data
imem_we  out  1  memory write enable
imem_q  in  DATA_WIDTH  memory read data (combinational, same cycle)
stall  in  1  hold IF/ID register and PC
redirect_valid  in  1  branch/jump taken
redirect_pc  in  ADDR_WIDTH  redirect target (word address)
if_instr  out  DATA_WIDTH  IF/ID instruction
if_pc  out  ADDR_WIDTH  IF/ID PC of if_instr
if_valid  out  1  IF/ID entry valid
halted  out  1  fetch stopped on HALT_INSTR

Behaviour:
- Addressing is word-based: PC increments by 1 and wraps at 2^ADDR_WIDTH. The memory uses the low address bits only.
- Reset (asynchronous) values:
  - state = S_WAIT, pc = RESET_PC, load_addr = 0
  - if_instr = 0, if_pc = 0, if_valid = 0
  - halted = 0, load_overflow = 0
- States:
  - S_WAIT: lasts 1 cycle. Goes to S_LOAD if load_mode = 1, else to S_RUN.
  - S_LOAD:
    - load_ready = 1.
    - imem_addr = load_addr, imem_data = load_data, imem_we = load_valid.
    - On each accepted word, load_addr increments.
    - If the accepted word has load_last = 1, or load_addr = MEM_SIZE-1: go to S_RUN and set pc = RESET_PC.
    - If the exit is at MEM_SIZE-1 with load_last = 0, set load_overflow (sticky until rst).
    - if_valid stays 0 throughout.
  - S_RUN:
    - imem_addr = pc, imem_we = 0, imem_data = 0, load_ready = 0.
  - S_HALT:
    - imem_addr = pc, imem_we = 0, halted = 1.
    - Only rst leaves this state.
- S_RUN per-posedge priority:
  1. redirect_valid: pc <= redirect_pc, if_valid <= 0 (flush). This applies even if stall = 1; a redirect always wins.
  2. stall: pc and the IF/ID register hold their values.
  3. Otherwise: if_instr <= imem_q, if_pc <= pc, if_valid <= 1, pc <= pc+1.
- Fetch latency: the word at pc appears on if_instr one cycle after pc is presented.
- Halt:
  - In case 3, if imem_q == HALT_INSTR, the halt word is still registered (if_valid = 1).
  - Then state goes to S_HALT and pc does not advance.
  - On following cycles in S_HALT, if_valid <= 0 unless stall = 1, in which case it holds.
  - A redirect in the same cycle as a halt fetch takes priority: no halt.
- Load handshake and reset:
  - A word is written iff load_valid & load_ready.
  - load_data must be stable while load_valid is high.
  - rst mid-load aborts immediately; the memory keeps whatever words were already written.
- Outputs never go X after reset; the imem_* outputs are combinational from state, pc, load_addr and the load inputs.

Decomposition:
- Shared package ifu_pkg:
  - state enum: S_WAIT, S_LOAD, S_RUN, S_HALT
  - HALT_INSTR default constant
  - instruction-width typedef, shared with decode
- No sub-module is required; the IF/ID register stays inline.
- Optional sub-module ifu_loader (load_addr counter, handshake, overflow flag) if reuse by a data-memory loader is wanted.

Test Plan:
- Loader, normal: rst, load_mode = 1; send 16'h1111, 16'h2222, 16'h3333, with load_last on 16'h3333.
  -> Memory words 0..2 hold these values. Next, state is S_RUN with pc = 0. if_instr/if_pc read (16'h1111, 0), (16'h2222, 1), (16'h3333, 2) on consecutive cycles, with if_valid = 1.
- Stall: hold stall = 1 for 3 cycles after if_pc = 1.
  -> if_pc stays 1, if_instr stays 16'h2222, imem_addr stays 2. After release, if_pc = 2 next cycle.
- Redirect plus stall: redirect_valid = 1, redirect_pc = 16'h0040, stall = 1 in the same cycle.
  -> Next cycle: if_valid = 0, imem_addr = 16'h0040. The following cycle: if_pc = 16'h0040, if_valid = 1.
- Halt: 16'hFFFF is stored at address 5.
  -> if_instr = 16'hFFFF, if_pc = 5 with if_valid = 1. Then halted = 1, if_valid = 0, imem_addr stays 5 indefinitely.
- Overflow: MEM_SIZE = 4; stream 6 words with load_last never asserted.
  -> Exactly 4 words are written. load_overflow = 1, load_ready = 0 afterwards, and S_RUN starts at pc = 0.
- Asynchronous reset mid-run: assert rst between clock edges while if_valid = 1 and pc = 7.
  -> if_valid = 0, pc = 0 and halted = 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared fetch/decode definitions: fetch state encoding, instruction word type, halt encoding.
package ifu_pkg;
  localparam int INSTR_WIDTH = 16;

  typedef logic [INSTR_WIDTH-1:0] instr_t;

  localparam instr_t HALT_INSTR_DEF = 16'hFFFF;

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_HALT = 2'd3
  } ifu_state_e;
endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bundle of loader handshake, instruction-memory bus, pipeline control and IF/ID outputs.
// master = fetch unit side, slave = loader / memory / pipeline side.
interface instr_fetch_unit_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
);
  logic                  load_mode;
  logic                  load_valid;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_last;
  logic                  load_ready;
  logic                  load_overflow;

  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] imem_data;
  logic                  imem_we;
  logic [DATA_WIDTH-1:0] imem_q;

  logic                  stall;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;

  logic [DATA_WIDTH-1:0] if_instr;
  logic [ADDR_WIDTH-1:0] if_pc;
  logic                  if_valid;
  logic                  halted;

  modport master (
    input  load_mode, load_valid, load_data, load_last, imem_q,
           stall, redirect_valid, redirect_pc,
    output load_ready, load_overflow, imem_addr, imem_data, imem_we,
           if_instr, if_pc, if_valid, halted
  );

  modport slave (
    output load_mode, load_valid, load_data, load_last, imem_q,
           stall, redirect_valid, redirect_pc,
    input  load_ready, load_overflow, imem_addr, imem_data, imem_we,
           if_instr, if_pc, if_valid, halted
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: boot loader into instruction memory, then PC sequencing
// with stall, redirect/flush and halt, feeding the IF/ID pipeline register.
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    MEM_SIZE   = 1024,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [DATA_WIDTH-1:0] HALT_INSTR = DATA_WIDTH'(HALT_INSTR_DEF)
) (
  input  logic               clk,
  input  logic               rst,
  instr_fetch_unit_if.master bus
);
  // Last writable word; the loader stops here even without load_last.
  localparam logic [ADDR_WIDTH-1:0] LOAD_END = ADDR_WIDTH'(MEM_SIZE - 1);

  ifu_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] load_addr_q, load_addr_d;
  logic [ADDR_WIDTH-1:0] if_pc_q, if_pc_d;
  logic [DATA_WIDTH-1:0] if_instr_q, if_instr_d;
  logic                  if_valid_q, if_valid_d;
  logic                  load_overflow_q, load_overflow_d;

  logic load_accept;
  logic load_exit;
  logic fetch_halt;

  assign load_accept = (state_q == S_LOAD) && bus.load_valid;
  assign load_exit   = load_accept && (bus.load_last || (load_addr_q == LOAD_END));
  // A halt word only takes effect on a real fetch (no redirect, no stall).
  assign fetch_halt  = !bus.redirect_valid && !bus.stall && (bus.imem_q == HALT_INSTR);

  // State register and all datapath flops; reset clears everything asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_WAIT;
      pc_q            <= RESET_PC;
      load_addr_q     <= '0;
      if_pc_q         <= '0;
      if_instr_q      <= '0;
      if_valid_q      <= 1'b0;
      load_overflow_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      load_addr_q     <= load_addr_d;
      if_pc_q         <= if_pc_d;
      if_instr_q      <= if_instr_d;
      if_valid_q      <= if_valid_d;
      load_overflow_q <= load_overflow_d;
    end
  end

  // Next-state logic: one wait cycle, optional load, run until a halt word is fetched.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT:  state_d = bus.load_mode ? S_LOAD : S_RUN;
      S_LOAD:  if (load_exit) state_d = S_RUN;
      S_RUN:   if (fetch_halt) state_d = S_HALT;
      default: state_d = state_q;
    endcase
  end

  // Datapath next values: loader counter, PC and IF/ID register.
  always_comb begin
    pc_d            = pc_q;
    load_addr_d     = load_addr_q;
    if_pc_d         = if_pc_q;
    if_instr_d      = if_instr_q;
    if_valid_d      = if_valid_q;
    load_overflow_d = load_overflow_q;
    case (state_q)
      S_LOAD: begin
        if (load_accept) load_addr_d = load_addr_q + ADDR_WIDTH'(1);
        if (load_exit) begin
          pc_d = RESET_PC;
          if (!bus.load_last) load_overflow_d = 1'b1;
        end
      end
      S_RUN: begin
        if (bus.redirect_valid) begin
          // Redirect beats stall: the in-flight entry is from the wrong path.
          pc_d       = bus.redirect_pc;
          if_valid_d = 1'b0;
        end else if (!bus.stall) begin
          if_instr_d = bus.imem_q;
          if_pc_d    = pc_q;
          if_valid_d = 1'b1;
          if (!fetch_halt) pc_d = pc_q + ADDR_WIDTH'(1);
        end
      end
      S_HALT: begin
        if (!bus.stall) if_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Output decode: memory bus is owned by the loader in S_LOAD, by the PC otherwise.
  always_comb begin
    bus.load_ready = 1'b0;
    bus.imem_addr  = pc_q;
    bus.imem_data  = '0;
    bus.imem_we    = 1'b0;
    bus.halted     = 1'b0;
    case (state_q)
      S_LOAD: begin
        bus.load_ready = 1'b1;
        bus.imem_addr  = load_addr_q;
        bus.imem_data  = bus.load_data;
        bus.imem_we    = bus.load_valid;
      end
      S_HALT:  bus.halted = 1'b1;
      default: ;
    endcase
  end

  assign bus.if_instr      = if_instr_q;
  assign bus.if_pc         = if_pc_q;
  assign bus.if_valid      = if_valid_q;
  assign bus.load_overflow = load_overflow_q;
endmodule
